// File: rtl/llc_output_encoder.sv
// llc_output_encoder
// Outbound message encoder for the LLC. It accepts one message bundle per
// transaction: a destination mask plus one payload per channel. All masked
// payloads go into their per-channel FIFOs together, in the same cycle. Each
// FIFO drains on its own valid/ready channel toward the NoC/DMA interfaces.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   send_valid/send_ready     bundle handshake from the LLC process pipeline
//   send_mask[4:0]            destinations: 0 rsp, 1 fwd, 2 mem, 3 dma, 4 inv
//   {rsp,fwd,mem,dma,inv}_in  per-channel payloads, sampled on accept
//   *_out_valid/_ready/_data  per-channel output streams (head of FIFO)
//   full[4:0]                 per-channel FIFO full, same bit order as mask
//   idle                      all FIFOs empty and no bundle presented

module llc_enc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign out_valid = (count != '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign out_data  = mem[rd_ptr];
    // The encoder never pushes into a full FIFO; the guard keeps the
    // FIFO self-protecting if that ever changes.
    assign do_push   = push & ~full;
    assign do_pop    = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module llc_output_encoder #(
    parameter int DEPTH = 2,
    parameter int RSP_W = 160,
    parameter int FWD_W = 48,
    parameter int MEM_W = 164,
    parameter int DMA_W = 200,
    parameter int INV_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send_valid,
    input  logic [4:0]       send_mask,
    output logic             send_ready,
    input  logic [RSP_W-1:0] rsp_in,
    input  logic [FWD_W-1:0] fwd_in,
    input  logic [MEM_W-1:0] mem_in,
    input  logic [DMA_W-1:0] dma_in,
    input  logic [INV_W-1:0] inv_in,
    output logic             rsp_out_valid,
    output logic             fwd_out_valid,
    output logic             mem_out_valid,
    output logic             dma_out_valid,
    output logic             inv_out_valid,
    input  logic             rsp_out_ready,
    input  logic             fwd_out_ready,
    input  logic             mem_out_ready,
    input  logic             dma_out_ready,
    input  logic             inv_out_ready,
    output logic [RSP_W-1:0] rsp_out_data,
    output logic [FWD_W-1:0] fwd_out_data,
    output logic [MEM_W-1:0] mem_out_data,
    output logic [DMA_W-1:0] dma_out_data,
    output logic [INV_W-1:0] inv_out_data,
    output logic [4:0]       full,
    output logic             idle
);
    logic       fire;
    logic [4:0] push;

    // send_ready looks only at registered FIFO state. A pop in this cycle
    // does not free a slot until the next edge, so there is no ready-through
    // path from the consumers back to the pipeline.
    assign send_ready = &(~send_mask | ~full);
    assign fire       = send_valid & send_ready;
    assign push       = {5{fire}} & send_mask;
    assign idle       = ~(rsp_out_valid | fwd_out_valid | mem_out_valid |
                          dma_out_valid | inv_out_valid) & ~send_valid;

    llc_enc_fifo #(.W(RSP_W), .DEPTH(DEPTH)) u_rsp (
        .clk(clk), .rst(rst), .push(push[0]), .din(rsp_in),
        .out_ready(rsp_out_ready), .out_valid(rsp_out_valid),
        .out_data(rsp_out_data), .full(full[0]));

    llc_enc_fifo #(.W(FWD_W), .DEPTH(DEPTH)) u_fwd (
        .clk(clk), .rst(rst), .push(push[1]), .din(fwd_in),
        .out_ready(fwd_out_ready), .out_valid(fwd_out_valid),
        .out_data(fwd_out_data), .full(full[1]));

    llc_enc_fifo #(.W(MEM_W), .DEPTH(DEPTH)) u_mem (
        .clk(clk), .rst(rst), .push(push[2]), .din(mem_in),
        .out_ready(mem_out_ready), .out_valid(mem_out_valid),
        .out_data(mem_out_data), .full(full[2]));

    llc_enc_fifo #(.W(DMA_W), .DEPTH(DEPTH)) u_dma (
        .clk(clk), .rst(rst), .push(push[3]), .din(dma_in),
        .out_ready(dma_out_ready), .out_valid(dma_out_valid),
        .out_data(dma_out_data), .full(full[3]));

    llc_enc_fifo #(.W(INV_W), .DEPTH(DEPTH)) u_inv (
        .clk(clk), .rst(rst), .push(push[4]), .din(inv_in),
        .out_ready(inv_out_ready), .out_valid(inv_out_valid),
        .out_data(inv_out_data), .full(full[4]));
endmodule

// File: tb/tb_llc_output_encoder.sv
// Testbench for llc_output_encoder: directed scenarios followed by random
// traffic, all checked against a per-channel list model of the FIFOs.
module tb_llc_output_encoder;
    localparam int DEPTH = 2;
    localparam int RSP_W = 160;
    localparam int FWD_W = 48;
    localparam int MEM_W = 164;
    localparam int DMA_W = 200;
    localparam int INV_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic             send_valid = 1'b0;
    logic [4:0]       send_mask  = '0;
    logic             send_ready;
    logic [4:0]       ordy = '0;
    logic [4:0]       ovld;
    logic [4:0]       full;
    logic             idle;
    logic [255:0]     din  [5];
    logic [255:0]     dout [5];
    logic [RSP_W-1:0] rsp_out_data;
    logic [FWD_W-1:0] fwd_out_data;
    logic [MEM_W-1:0] mem_out_data;
    logic [DMA_W-1:0] dma_out_data;
    logic [INV_W-1:0] inv_out_data;

    assign dout[0] = 256'(rsp_out_data);
    assign dout[1] = 256'(fwd_out_data);
    assign dout[2] = 256'(mem_out_data);
    assign dout[3] = 256'(dma_out_data);
    assign dout[4] = 256'(inv_out_data);

    llc_output_encoder #(
        .DEPTH(DEPTH), .RSP_W(RSP_W), .FWD_W(FWD_W),
        .MEM_W(MEM_W), .DMA_W(DMA_W), .INV_W(INV_W)
    ) dut (
        .clk(clk), .rst(rst),
        .send_valid(send_valid), .send_mask(send_mask), .send_ready(send_ready),
        .rsp_in(din[0][RSP_W-1:0]), .fwd_in(din[1][FWD_W-1:0]),
        .mem_in(din[2][MEM_W-1:0]), .dma_in(din[3][DMA_W-1:0]),
        .inv_in(din[4][INV_W-1:0]),
        .rsp_out_valid(ovld[0]), .fwd_out_valid(ovld[1]),
        .mem_out_valid(ovld[2]), .dma_out_valid(ovld[3]),
        .inv_out_valid(ovld[4]),
        .rsp_out_ready(ordy[0]), .fwd_out_ready(ordy[1]),
        .mem_out_ready(ordy[2]), .dma_out_ready(ordy[3]),
        .inv_out_ready(ordy[4]),
        .rsp_out_data(rsp_out_data), .fwd_out_data(fwd_out_data),
        .mem_out_data(mem_out_data), .dma_out_data(dma_out_data),
        .inv_out_data(inv_out_data),
        .full(full), .idle(idle));

    int total = 0;
    int bad   = 0;
    int wid [5] = '{RSP_W, FWD_W, MEM_W, DMA_W, INV_W};

    // Reference model: each channel is an ordered list of pending payloads.
    logic [255:0] mq   [5][8];
    int           mcnt [5];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd(input int c);
        logic [255:0] r;
        logic [255:0] m;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        m = (256'd1 << wid[c]) - 256'd1;
        return r & m;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 5; c++) mcnt[c] = 0;
    endtask

    // One clock cycle. Called just after a falling edge; returns just after
    // the next falling edge.
    task automatic step(input logic v, input logic [4:0] mk, input logic [4:0] rdy);
        logic       exp_rdy;
        logic [4:0] exp_full;
        logic       exp_idle;
        logic       fire;
        send_valid = v;
        send_mask  = mk;
        ordy       = rdy;
        #1;
        exp_rdy  = 1'b1;
        exp_idle = !v;
        for (int c = 0; c < 5; c++) begin
            exp_full[c] = (mcnt[c] == DEPTH);
            if (mk[c] && mcnt[c] == DEPTH) exp_rdy = 1'b0;
            if (mcnt[c] != 0) exp_idle = 1'b0;
        end
        chk("send_ready", 256'(send_ready), 256'(exp_rdy));
        chk("full", 256'(full), 256'(exp_full));
        chk("idle", 256'(idle), 256'(exp_idle));
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("valid%0d", c), 256'(ovld[c]), 256'(mcnt[c] != 0));
            if (mcnt[c] != 0) chk($sformatf("data%0d", c), dout[c], mq[c][0]);
        end
        @(posedge clk);
        fire = v && exp_rdy;
        for (int c = 0; c < 5; c++) begin
            if (mcnt[c] != 0 && rdy[c]) begin
                for (int k = 0; k < 7; k++) mq[c][k] = mq[c][k+1];
                mcnt[c]--;
            end
            if (fire && mk[c]) begin
                mq[c][mcnt[c]] = din[c];
                mcnt[c]++;
            end
            chk($sformatf("model_bound%0d", c), 256'(mcnt[c] <= DEPTH), 256'(1));
        end
        @(negedge clk);
    endtask

    task automatic rand_din();
        for (int c = 0; c < 5; c++) din[c] = rnd(c);
    endtask

    initial begin
        model_clear();
        rand_din();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reset mid-traffic with two entries waiting in rsp.
        rand_din(); step(1'b1, 5'b00001, 5'b00000);
        rand_din(); step(1'b1, 5'b00001, 5'b00000);
        #2;
        rst        = 1'b0;
        send_valid = 1'b0;
        #1;
        chk("rst_valid", 256'(ovld), 256'(0));
        chk("rst_full", 256'(full), 256'(0));
        chk("rst_idle", 256'(idle), 256'(1));
        for (int c = 0; c < 5; c++) chk($sformatf("rst_data%0d", c), dout[c], 256'(0));
        model_clear();
        send_valid = 1'b1;
        send_mask  = 5'b11111;
        @(posedge clk);
        @(negedge clk);
        chk("rst_drop", 256'(ovld), 256'(0));
        rst = 1'b1;
        rand_din(); step(1'b1, 5'b00001, 5'b11111);
        step(1'b0, 5'b00000, 5'b11111);

        // Single bundle to rsp and mem.
        rand_din();
        din[0] = 256'hA5;
        din[2] = 256'h3C;
        step(1'b1, 5'b00101, 5'b11111);
        chk("single_rsp", dout[0], 256'hA5);
        chk("single_mem", dout[2], 256'h3C);
        step(1'b0, 5'b00000, 5'b11111);
        step(1'b0, 5'b00000, 5'b11111);

        // Atomic backpressure: fwd fills, then a rsp+fwd bundle must wait.
        rand_din(); step(1'b1, 5'b00010, 5'b11101);
        rand_din(); step(1'b1, 5'b00010, 5'b11101);
        rand_din(); step(1'b1, 5'b00011, 5'b11101);
        chk("atomic_no_rsp", 256'(ovld[0]), 256'(0));
        step(1'b1, 5'b00011, 5'b11111);
        step(1'b1, 5'b00011, 5'b11101);
        repeat (4) step(1'b0, 5'b00000, 5'b11111);

        // Hold stability on dma.
        rand_din();
        din[3] = 256'h1234;
        step(1'b1, 5'b01000, 5'b10111);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 5'b00000, 5'b10111);
            chk("hold_dma", dout[3], 256'h1234);
        end
        step(1'b0, 5'b00000, 5'b11111);

        // Back-to-back inv bundles 1..9, one per cycle.
        for (int i = 1; i <= 9; i++) begin
            rand_din();
            din[4] = 256'(i);
            step(1'b1, 5'b10000, 5'b11111);
            chk("inv_seq", dout[4], 256'(i));
        end
        step(1'b0, 5'b00000, 5'b11111);

        // rsp full with a simultaneous pop: push waits one cycle.
        rand_din(); step(1'b1, 5'b00001, 5'b11110);
        rand_din(); step(1'b1, 5'b00001, 5'b11110);
        rand_din(); step(1'b1, 5'b00001, 5'b11111);
        step(1'b1, 5'b00001, 5'b11111);
        repeat (3) step(1'b0, 5'b00000, 5'b11111);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rand_din();
            step($urandom_range(0, 3) != 0, 5'($urandom), 5'($urandom));
        end
        repeat (4) step(1'b0, 5'b00000, 5'b11111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/llc_output_encoder.md
Name: llc_output_encoder

Overview:
- Outbound counterpart to the LLC input decoder.
- The LLC process pipeline presents one message bundle per transaction. The bundle is a mask of destination channels plus a payload per channel.
- The block accepts the whole bundle atomically into per-channel buffers. It then drives five independent valid/ready output channels toward the NoC/DMA interfaces, and backpressures the pipeline when any targeted channel is full.

Parameters:
DEPTH, 2, entries per channel FIFO (power of two, ≥2)
RSP_W, 160, rsp_out payload width (to L2)
FWD_W, 48, fwd_out payload width (to L2)
MEM_W, 164, mem_req payload width (to memory)
DMA_W, 200, dma_rsp payload width (to DMA)
INV_W, 32, inv_out payload width (invalidation broadcast)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
send_valid  in  1  pipeline presents a bundle
send_mask  in  5  destinations: bit0 rsp, bit1 fwd, bit2 mem, bit3 dma, bit4 inv
send_ready  out  1  bundle accepted this cycle when send_valid & send_ready
rsp_in / fwd_in / mem_in / dma_in / inv_in  in  RSP_W/FWD_W/MEM_W/DMA_W/INV_W  per-channel payloads
rsp_out_valid / fwd_out_valid / mem_out_valid / dma_out_valid / inv_out_valid  out  1  channel has data
rsp_out_ready / fwd_out_ready / mem_out_ready / dma_out_ready / inv_out_ready  in  1  consumer accepts
rsp_out_data / fwd_out_data / mem_out_data / dma_out_data / inv_out_data  out  widths as above  head-of-FIFO payload
full  out  5  per-channel FIFO full, same bit order as send_mask
idle  out  1  all FIFOs empty and no bundle presented

Behaviour:
- Reset (async, rst=0):
  - All read/write pointers and counts clear.
  - All *_out_valid=0, full=0, idle=1 immediately.
  - Data outputs read 0.
  - Any bundle presented during reset is dropped.
- send_ready is combinational and registered-state only:
  - send_ready = AND over c of (!send_mask[c] | !full_reg[c]).
  - It does not depend on same-cycle out_ready: no ready-through path.
- Accept (fire = send_valid & send_ready):
  - Every channel with send_mask[c]=1 pushes its payload in the same cycle.
  - Channels with mask bit 0 are untouched; their payload inputs are ignored.
- Atomicity: if any masked channel is full, send_ready=0 and no channel pushes, including non-full ones. The pipeline holds the bundle stable until accepted.
- send_mask=0 with send_valid=1: send_ready=1, accepted as a no-op.
- Per-channel FIFO:
  - First-word latency: push at edge N, out_valid=1 and data valid after edge N.
  - Pop occurs when out_valid & out_ready.
  - out_valid = count≠0; data = mem[rd_ptr], driven from registers.
  - out_data and out_valid are held stable while out_valid=1 and out_ready=0.
- Count update per edge: push only → +1; pop only → −1; push and pop on the same edge (only possible when not full) → count unchanged, both pointers advance.
- Full FIFO with pop in the same cycle: push is still blocked that cycle; it is accepted next cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Ordering:
  - Per-channel order is FIFO order.
  - No ordering is guaranteed across channels. Channels drain independently, with no arbitration between them.
- full[c] = (count_c==DEPTH).
- idle = (all counts 0) & !send_valid, combinational.
- No overflow or underflow is possible by construction. The bench asserts this.

Test Plan:
- Reset then idle: rst low mid-traffic with 2 entries in rsp → all out_valid=0, full=0, idle=1 within the reset cycle; after release the first bundle is accepted at once.
- Single bundle: send_valid=1, mask=5'b00101, rsp_in=0xA5, mem_in=0x3C, all readies 1 → send_ready=1; rsp_out_valid and mem_out_valid high for exactly 1 cycle after the edge with data 0xA5/0x3C; other channels stay 0.
- Atomic backpressure: fwd_out_ready=0, push 2 bundles mask=5'b00010 → full=5'b00010. Then mask=5'b00011 → send_ready=0 and rsp gets no push. Raise fwd_out_ready for 1 cycle → next cycle send_ready=1, both channels push.
- Hold stability: dma_out_ready=0 for 10 cycles with dma_in=0x1234 queued → dma_out_valid=1 and data=0x1234 unchanged for all 10 cycles.
- Wrap-around/throughput: inv channel, ready=1, 9 back-to-back bundles with payloads 1..9 → inv_out_data sequence is 1..9 at 1 per cycle; count never exceeds 1; pointers wrap 4 times.
- Full with simultaneous pop: rsp count=2, rsp_out_ready=1 and mask=5'b00001 → send_ready=0 that cycle, count→1; next cycle accepted, count→1 with pop, data order preserved.
